// File: rtl/dmgplus_rom_arbiter_pkg.sv
// Shared types for the cartridge ROM arbiter: cart cycle states and bus owner codes.
package dmgplus_rom_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RECOVER = 2'd3
    } cyc_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_SPL = 1'b1
    } owner_t;

endpackage

// File: rtl/dmgplus_cart_cycle.sv
// One cart read cycle: SETUP, ACCESS_CYCLES of STROBE, RECOVER. Drives the cart pins.
// It pulses capture on the last strobe cycle so the owner latches cart data at that edge.
module dmgplus_cart_cycle
    import dmgplus_rom_arbiter_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk_8m,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] cart_addr,
    output logic              cart_cs_n,
    output logic              cart_rd_n,
    output logic              capture,
    output logic              idle
);

    cyc_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk_8m) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cart_addr <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Address is held through RECOVER and until the next grant.
            if (start && state == ST_IDLE) begin
                cart_addr <= addr;
            end
        end
    end

    // NOTE: every output of this block is given a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cart_cs_n = 1'b1;
        cart_rd_n = 1'b1;
        capture   = 1'b0;
        idle      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                idle = 1'b1;
                if (start) begin
                    state_nxt = ST_SETUP;
                    cnt_nxt   = '0;
                end
            end
            ST_SETUP: begin
                cart_cs_n = 1'b0;
                state_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                cart_cs_n = 1'b0;
                cart_rd_n = 1'b0;
                if (cnt == CNT_W'(ACCESS_CYCLES - 1)) begin
                    capture   = 1'b1;
                    state_nxt = ST_RECOVER;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_RECOVER: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/dmgplus_rom_arbiter.sv
// Shares the cartridge ROM bus between the splash generator and the CPU core.
// Holds the request latches, fixed-priority arbiter with SPL anti-starvation, and read data registers.
module dmgplus_rom_arbiter
    import dmgplus_rom_arbiter_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int SPL_STARVE    = 4
) (
    input  logic              clk_8m,
    input  logic              rst,
    input  logic              spl_en,
    input  logic [ADDR_W-1:0] spl_addr,
    input  logic              spl_rd,
    output logic              spl_bsy,
    output logic [DATA_W-1:0] spl_data,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    output logic              cpu_bsy,
    output logic [DATA_W-1:0] cpu_data,
    output logic [ADDR_W-1:0] cart_addr,
    output logic              cart_cs_n,
    output logic              cart_rd_n,
    input  logic [DATA_W-1:0] cart_din
);

    logic              pend_cpu, pend_spl;
    logic              act_cpu, act_spl;
    logic [ADDR_W-1:0] addr_cpu, addr_spl;
    owner_t            owner;
    logic [CNT_W-1:0]  starve_cnt;

    logic accept_cpu, accept_spl, spl_live;
    logic grant_cpu, grant_spl, start;
    logic capture, idle;

    assign accept_cpu = cpu_rd & ~pend_cpu & ~act_cpu;
    assign accept_spl = spl_rd & spl_en & ~pend_spl & ~act_spl;
    assign spl_live   = pend_spl & spl_en;

    // CPU wins unless SPL has waited out SPL_STARVE consecutive CPU grants.
    assign grant_spl = idle & spl_live & (~pend_cpu | (starve_cnt == CNT_W'(SPL_STARVE)));
    assign grant_cpu = idle & pend_cpu & ~grant_spl;
    assign start     = grant_cpu | grant_spl;

    assign cpu_bsy = accept_cpu | pend_cpu | act_cpu;
    assign spl_bsy = spl_en & (accept_spl | pend_spl | act_spl);

    dmgplus_cart_cycle #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_cart_cycle (
        .clk_8m   (clk_8m),
        .rst      (rst),
        .start    (start),
        .addr     (grant_spl ? addr_spl : addr_cpu),
        .cart_addr(cart_addr),
        .cart_cs_n(cart_cs_n),
        .cart_rd_n(cart_rd_n),
        .capture  (capture),
        .idle     (idle)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            pend_cpu   <= 1'b0;
            pend_spl   <= 1'b0;
            act_cpu    <= 1'b0;
            act_spl    <= 1'b0;
            addr_cpu   <= '0;
            addr_spl   <= '0;
            owner      <= OWN_CPU;
            starve_cnt <= '0;
            cpu_data   <= '0;
            spl_data   <= '0;
        end else begin
            if (accept_cpu) begin
                pend_cpu <= 1'b1;
                addr_cpu <= cpu_addr;
            end else if (grant_cpu) begin
                pend_cpu <= 1'b0;
            end

            if (!spl_en) begin
                pend_spl <= 1'b0;
            end else if (accept_spl) begin
                pend_spl <= 1'b1;
                addr_spl <= spl_addr;
            end else if (grant_spl) begin
                pend_spl <= 1'b0;
            end

            if (grant_cpu)    act_cpu <= 1'b1;
            else if (capture) act_cpu <= 1'b0;
            if (grant_spl)    act_spl <= 1'b1;
            else if (capture) act_spl <= 1'b0;

            if (start) begin
                owner <= grant_spl ? OWN_SPL : OWN_CPU;
            end

            // A locked-out SPL still finishes its pin cycle but never sees the data.
            if (capture) begin
                if (owner == OWN_CPU)  cpu_data <= cart_din;
                else if (spl_en)       spl_data <= cart_din;
            end

            if (grant_spl || !spl_live) starve_cnt <= '0;
            else if (grant_cpu)         starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dmgplus_rom_arbiter.sv
// Directed bench for dmgplus_rom_arbiter: latency, priority, starvation, lockout, reset, re-request.
module tb_dmgplus_rom_arbiter;

    logic        clk_8m = 1'b0;
    logic        rst;
    logic        spl_en;
    logic [15:0] spl_addr;
    logic        spl_rd;
    logic        spl_bsy;
    logic [7:0]  spl_data;
    logic [15:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_bsy;
    logic [7:0]  cpu_data;
    logic [15:0] cart_addr;
    logic        cart_cs_n;
    logic        cart_rd_n;
    logic [7:0]  cart_din;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_8m = ~clk_8m;

    dmgplus_rom_arbiter dut (
        .clk_8m   (clk_8m),
        .rst      (rst),
        .spl_en   (spl_en),
        .spl_addr (spl_addr),
        .spl_rd   (spl_rd),
        .spl_bsy  (spl_bsy),
        .spl_data (spl_data),
        .cpu_addr (cpu_addr),
        .cpu_rd   (cpu_rd),
        .cpu_bsy  (cpu_bsy),
        .cpu_data (cpu_data),
        .cart_addr(cart_addr),
        .cart_cs_n(cart_cs_n),
        .cart_rd_n(cart_rd_n),
        .cart_din (cart_din)
    );

    // Cart ROM model: 0x0100 -> 0x44, 0x0150 -> 0x14, 0x0134 -> 0x70, 0x0200 -> 0x47.
    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h45;
    endfunction

    assign cart_din = rom_byte(cart_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_8m);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] glog [6];
        logic [15:0] exp_order [6];
        int grants;
        int cpu_reqs;
        int cs_cnt;
        int setups;

        exp_order = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h0200, 16'h1004};
        rst = 1'b1; spl_en = 1'b1; spl_addr = '0; spl_rd = 1'b0; cpu_addr = '0; cpu_rd = 1'b0;
        tick; tick;
        rst = 1'b0;
        #1;
        check("rst cart_addr", cart_addr, 16'h0000);
        check("rst cart_cs_n", cart_cs_n, 1);
        check("rst cart_rd_n", cart_rd_n, 1);
        check("rst spl_data", spl_data, 8'h00);
        check("rst cpu_data", cpu_data, 8'h00);
        check("rst spl_bsy", spl_bsy, 0);
        check("rst cpu_bsy", cpu_bsy, 0);

        // 1: lone SPL read
        tick;
        spl_addr = 16'h0100; spl_rd = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            check($sformatf("t1 spl_bsy c%0d", c), spl_bsy, (c < 5));
            check($sformatf("t1 cart_rd_n c%0d", c), cart_rd_n, !(c == 3 || c == 4));
            tick;
            spl_rd = 1'b0;
        end
        check("t1 spl_data", spl_data, 8'h44);
        check("t1 cpu_data", cpu_data, 8'h00);

        // 2: simultaneous requests, CPU first
        spl_addr = 16'h0134; cpu_addr = 16'h0150; spl_rd = 1'b1; cpu_rd = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            check($sformatf("t2 cpu_bsy c%0d", c), cpu_bsy, (c < 5));
            check($sformatf("t2 spl_bsy c%0d", c), spl_bsy, (c < 10));
            if (c == 2) check("t2 first addr", cart_addr, 16'h0150);
            if (c == 7) check("t2 second addr", cart_addr, 16'h0134);
            tick;
            spl_rd = 1'b0; cpu_rd = 1'b0;
        end
        check("t2 cpu_data", cpu_data, 8'h14);
        check("t2 spl_data", spl_data, 8'h70);

        // 3: CPU hammers the bus while SPL waits
        grants = 0;
        spl_addr = 16'h0200; spl_rd = 1'b1; cpu_addr = 16'h1000; cpu_rd = 1'b1; cpu_reqs = 1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            #1;
            if (!cart_cs_n && cart_rd_n) begin
                if (grants < 6) glog[grants] = cart_addr;
                grants++;
            end
            if (grants >= 6) break;
            tick;
            spl_rd = 1'b0; cpu_rd = 1'b0;
            #1;
            if (!cpu_bsy && cpu_reqs < 5) begin
                cpu_addr = 16'(32'h1000 + cpu_reqs);
                cpu_rd = 1'b1;
                cpu_reqs++;
            end
        end
        check("t3 grant count", grants, 6);
        for (int g = 0; g < 6; g++) begin
            if (g < grants) check($sformatf("t3 grant %0d addr", g), glog[g], exp_order[g]);
        end
        repeat (12) begin
            tick;
            spl_rd = 1'b0; cpu_rd = 1'b0;
        end
        check("t3 spl_data", spl_data, 8'h47);
        check("t3 cpu_data", cpu_data, 8'h51);

        // 4: SPL lockout during its own strobe
        spl_addr = 16'h0300; spl_rd = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 3) spl_en = 1'b0;
            #1;
            if (c == 2) check("t4 spl_bsy before drop", spl_bsy, 1);
            if (c >= 3) check($sformatf("t4 spl_bsy c%0d", c), spl_bsy, 0);
            if (c == 3 || c == 4) check($sformatf("t4 cart_rd_n c%0d", c), cart_rd_n, 0);
            if (c == 5) check("t4 cart_cs_n recover", cart_cs_n, 1);
            tick;
            spl_rd = 1'b0;
        end
        check("t4 spl_data held", spl_data, 8'h47);
        spl_addr = 16'h0555; spl_rd = 1'b1;
        #1;
        check("t4 locked spl_bsy", spl_bsy, 0);
        cs_cnt = 0;
        repeat (8) begin
            tick;
            spl_rd = 1'b0;
            #1;
            if (!cart_cs_n) cs_cnt++;
        end
        check("t4 locked cart cycles", cs_cnt, 0);
        spl_en = 1'b1;
        tick;
        #1;
        check("t4 reenable spl_bsy", spl_bsy, 0);

        // 5: reset in the middle of a strobe
        cpu_addr = 16'h2000; cpu_rd = 1'b1;
        tick; cpu_rd = 1'b0;
        tick; tick;
        #1;
        check("t5 in strobe", cart_rd_n, 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        check("t5 cart_cs_n", cart_cs_n, 1);
        check("t5 cart_rd_n", cart_rd_n, 1);
        check("t5 cart_addr", cart_addr, 16'h0000);
        check("t5 cpu_data", cpu_data, 8'h00);
        check("t5 spl_data", spl_data, 8'h00);
        check("t5 cpu_bsy", cpu_bsy, 0);
        check("t5 spl_bsy", spl_bsy, 0);
        tick;
        cpu_addr = 16'h0123; cpu_rd = 1'b1;
        for (int c = 0; c < 7; c++) begin
            #1;
            check($sformatf("t5 cpu_bsy c%0d", c), cpu_bsy, (c < 5));
            tick;
            cpu_rd = 1'b0;
        end
        check("t5 cpu_data", cpu_data, 8'h67);

        // 6: repeat requests while busy are ignored
        cpu_addr = 16'h0456; cpu_rd = 1'b1; setups = 0;
        for (int c = 0; c < 11; c++) begin
            #1;
            if (!cart_cs_n && cart_rd_n) begin
                setups++;
                check("t6 cart_addr", cart_addr, 16'h0456);
            end
            tick;
            cpu_rd = 1'b0;
            if (c == 0 || c == 2) begin
                cpu_addr = 16'h0789; cpu_rd = 1'b1;
            end
        end
        #1;
        check("t6 cart cycles", setups, 1);
        check("t6 cpu_data", cpu_data, 8'h17);
        check("t6 cpu_bsy", cpu_bsy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
